// File: rtl/random_delay_pkg.sv
// -----------------------------------------------------------------------------
// random_delay_pkg
// Shared definitions for the random_delay block:
//   - state_t / ST_* : FSM state encoding (IDLE, WAIT, DONE)
//   - DEFAULT_UNIT   : default clock cycles per random step
//   - cnt_width()    : width of the delay down-counter for a given UNIT
// -----------------------------------------------------------------------------
package random_delay_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int DEFAULT_UNIT = 4;

    // The largest value ever loaded is 8*UNIT-1, so clog2(8*UNIT) bits suffice.
    function automatic int cnt_width(input int unit);
        return $clog2(8 * unit);
    endfunction

endpackage

// File: rtl/random_delay_counter.sv
// -----------------------------------------------------------------------------
// delay_counter
// Loadable down-counter used to time one random delay.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset (count cleared to 0)
//   load_i     : load load_val_i this edge (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement this edge (saturates at 0)
//   zero_o     : count is currently zero
// -----------------------------------------------------------------------------
module delay_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/random_delay.sv
// -----------------------------------------------------------------------------
// random_delay
// Consumes a 3-bit pseudo-random value and waits (value+1)*UNIT cycles, then
// pulses done for one cycle. rnd_take pulses the cycle after each capture so the
// generator advances exactly once per consumed value.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset (aborts any running delay)
//   rnd      : current generator value
//   start    : delay request, sampled on rising edge
//   rnd_take : one-cycle pulse after rnd has been captured
//   busy     : high while a delay is running
//   done     : one-cycle pulse when the delay expires
//   value    : rnd captured for the current or most recent delay
// Build option:
//   RANDOM_DELAY_RETRIGGER_EN : when defined, start during a running delay
//   recaptures rnd and restarts the delay without a done pulse.
// -----------------------------------------------------------------------------
module random_delay
    import random_delay_pkg::*;
#(
    parameter int UNIT  = DEFAULT_UNIT,
    parameter int CNT_W = cnt_width(UNIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rnd,
    input  logic       start,
    output logic       rnd_take,
    output logic       busy,
    output logic       done,
    output logic [2:0] value
);

    localparam logic [CNT_W-1:0] UNIT_W  = CNT_W'(UNIT);
    localparam logic [CNT_W-1:0] UNIT_M1 = CNT_W'(UNIT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] value_q;
    logic [2:0] value_d;
    logic       take_q;
    logic       take_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    // (rnd+1)*UNIT-1 written as rnd*UNIT + (UNIT-1): the peak is 8*UNIT-1,
    // which always fits in CNT_W bits, so no intermediate overflow.
    assign cnt_load_val = CNT_W'(rnd) * UNIT_W + UNIT_M1;

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        take_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_WAIT;
                    value_d  = rnd;
                    take_d   = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ST_WAIT: begin
`ifdef RANDOM_DELAY_RETRIGGER_EN
                if (start) begin
                    value_d  = rnd;
                    take_d   = 1'b1;
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
`else
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                // A start here chains straight into the next delay.
                if (start) begin
                    state_d  = ST_WAIT;
                    value_d  = rnd;
                    take_d   = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            value_q <= 3'b000;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            take_q  <= take_d;
        end
    end

    delay_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // All outputs come straight from registers.
    assign busy     = (state_q == ST_WAIT);
    assign done     = (state_q == ST_DONE);
    assign rnd_take = take_q;
    assign value    = value_q;

endmodule

// File: tb/tb_random_delay.sv
module tb_random_delay;

    logic       clk;
    logic       reset;
    logic [2:0] rnd;
    logic       start;
    logic       rnd_take;
    logic       busy;
    logic       done;
    logic [2:0] value;

    int checks;
    int errors;

    random_delay #(
        .UNIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rnd      (rnd),
        .start    (start),
        .rnd_take (rnd_take),
        .busy     (busy),
        .done     (done),
        .value    (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle start; returns just after the capture edge E0.
    task automatic start_delay(input logic [2:0] r, input string tag);
        rnd   = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_take"}, int'(rnd_take), 1);
        check({tag, "_busy0"}, int'(busy), 1);
        check({tag, "_value"}, int'(value), int'(r));
    endtask

    // Runs until done (bounded). Optionally drives a start at edge E0+poke_edge.
    task automatic measure(input int poke_edge, input logic [2:0] poke_rnd,
                           output int busy_n, output int takes, output int done_at);
        int c;
        c       = 0;
        busy_n  = int'(busy);
        takes   = int'(rnd_take);
        done_at = -1;
        while (done_at < 0 && c < 200) begin
            if (c + 1 == poke_edge) begin
                rnd   = poke_rnd;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
            busy_n += int'(busy);
            takes  += int'(rnd_take);
            if (done) done_at = c;
        end
        start = 1'b0;
        check("done_within_budget", int'(done_at >= 0), 1);
    endtask

    task automatic after_done(input string tag);
        tick();
        check({tag, "_done_1cyc"}, int'(done), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    task automatic plain_delay(input logic [2:0] r, input int exp_n, input string tag);
        int bn, tk, da;
        start_delay(r, tag);
        measure(-1, 3'd0, bn, tk, da);
        check({tag, "_busy_cycles"}, bn, exp_n);
        check({tag, "_done_at"}, da, exp_n);
        check({tag, "_takes"}, tk, 1);
        check({tag, "_value_end"}, int'(value), int'(r));
        $display("txn %s: rnd=%0d busy=%0d done_at=%0d takes=%0d", tag, r, bn, da, tk);
        after_done(tag);
    endtask

    initial begin
        int bn, tk, da;
        int d1, d2, d3, ndone, gaps, c, dcount;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        rnd    = 3'd0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_take", int'(rnd_take), 0);
        check("rst_value", int'(value), 0);
        reset = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);
        $display("txn reset: busy=%0d done=%0d value=%0d", busy, done, value);

        // Basic delays: N = (rnd+1)*4
        plain_delay(3'd3, 16, "rnd3");
        plain_delay(3'd0, 4, "rnd0");
        plain_delay(3'd7, 32, "rnd7");
        check("value_hold_idle", int'(value), 7);

`ifdef RANDOM_DELAY_RETRIGGER_EN
        // Retrigger at edge 10 with rnd=1: done 8 cycles after that edge.
        start_delay(3'd7, "retrig");
        measure(10, 3'd1, bn, tk, da);
        check("retrig_done_at", da, 18);
        check("retrig_busy_cont", bn, 18);
        check("retrig_takes", tk, 2);
        check("retrig_value", int'(value), 1);
        $display("txn retrig: busy=%0d done_at=%0d takes=%0d value=%0d", bn, da, tk, value);
        after_done("retrig");
`else
        // Start mid-delay is ignored.
        start_delay(3'd2, "ignore");
        measure(5, 3'd6, bn, tk, da);
        check("ignore_done_at", da, 12);
        check("ignore_busy", bn, 12);
        check("ignore_takes", tk, 1);
        check("ignore_value", int'(value), 2);
        $display("txn ignore: busy=%0d done_at=%0d takes=%0d value=%0d", bn, da, tk, value);
        after_done("ignore");
`endif

        // Back-to-back with start held; generator steps on each take.
        rnd   = 3'd1;
        start = 1'b1;
        tick();
        c = 0; ndone = 0; gaps = 0; tk = 0;
        d1 = -1; d2 = -1; d3 = -1;
        while (ndone < 3 && c < 200) begin
            if (rnd_take) begin
                tk++;
                rnd = rnd + 3'd1;
            end
            if (!busy && !done) gaps++;
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = c;
                if (ndone == 2) d2 = c;
                if (ndone == 3) begin
                    d3 = c;
                    start = 1'b0;
                end
            end
            if (ndone < 3) begin
                tick();
                c++;
            end
        end
        check("b2b_three_done", ndone, 3);
        check("b2b_first_done", d1, 8);
        check("b2b_gap12", d2 - d1, 13);
        check("b2b_gap23", d3 - d2, 17);
        check("b2b_no_idle", gaps, 0);
        check("b2b_takes", tk, 3);
        check("b2b_value", int'(value), 3);
        $display("txn b2b: done at %0d,%0d,%0d takes=%0d", d1, d2, d3, tk);
        after_done("b2b");

        // Reset mid-delay (priority over start), then normal operation.
        start_delay(3'd5, "rstmid");
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        start = 1'b1;
        rnd   = 3'd6;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_done", int'(done), 0);
        check("rstmid_take", int'(rnd_take), 0);
        check("rstmid_value", int'(value), 0);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            dcount += int'(done) + int'(busy);
        end
        check("rstmid_no_done", dcount, 0);
        $display("txn rstmid: aborted value=%0d", value);
        plain_delay(3'd4, 20, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
